// File: rtl/frame_fifo_writer.sv
// Packs a 24-bit pixel stream into 32-bit FIFO words and prefixes every frame with
// the 0x80000000 / 0x7FFFFFFF sync header; frames are aborted on overflow or bad input.
module frame_fifo_writer #(
   parameter int H_ACTIVE   = 720,
   parameter int V_ACTIVE   = 576,
   parameter int HDR_LEVEL  = 200,
   parameter int FULL_LEVEL = 252
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_vsync,
   input  logic        pix_valid,
   input  logic [23:0] pix_data,
   input  logic [7:0]  wr_use,
   output logic [31:0] fifo_data,
   output logic        fifo_wr,
   output logic        frame_done,
   output logic        frame_drop,
   output logic [15:0] drop_cnt
);

   localparam int                PIX_TOTAL = H_ACTIVE * V_ACTIVE;
   localparam int                CNT_W     = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1;
   localparam logic [CNT_W-1:0]  PIX_LAST  = CNT_W'(PIX_TOTAL - 1);
   localparam logic [8:0]        HDR_LVL   = 9'(HDR_LEVEL);
   localparam logic [8:0]        FULL_LVL  = 9'(FULL_LEVEL);
   localparam logic [31:0]       HDR_WORD0 = 32'h8000_0000;
   localparam logic [31:0]       HDR_WORD1 = 32'h7FFF_FFFF;

   // HDR0/HDR1 name the header word currently on the output register; each
   // header word is launched one state earlier so it lands at sof+1 / sof+2.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR0 = 3'd1,
      S_HDR1 = 3'd2,
      S_DATA = 3'd3,
      S_DROP = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
   logic             vs_q;
   logic             hdr_bad_q, hdr_bad_d;
   logic [31:0]      fifo_data_q, fifo_data_d;
   logic             fifo_wr_q, fifo_wr_d;
   logic             frame_done_q, frame_done_d;
   logic             frame_drop_q, frame_drop_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;
   logic             sof;
   logic             gate_ok;
   logic             room_ok;

   assign sof     = pix_vsync & ~vs_q;
   assign gate_ok = ({1'b0, wr_use} <= HDR_LVL);
   assign room_ok = ({1'b0, wr_use} < FULL_LVL);

   // Next-state, write and pulse generation
   always_comb begin
      state_d      = state_q;
      pix_cnt_d    = pix_cnt_q;
      hdr_bad_d    = hdr_bad_q;
      fifo_data_d  = fifo_data_q;
      fifo_wr_d    = 1'b0;
      frame_done_d = 1'b0;
      frame_drop_d = 1'b0;
      case (state_q)
         S_IDLE, S_DROP: begin
            if (sof) begin
               if (gate_ok) begin
                  fifo_wr_d   = 1'b1;
                  fifo_data_d = HDR_WORD0;
                  hdr_bad_d   = 1'b0;
                  state_d     = S_HDR0;
               end else begin
                  frame_drop_d = 1'b1;
                  state_d      = S_DROP;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_HDR0: begin
            fifo_wr_d   = 1'b1;
            fifo_data_d = HDR_WORD1;
            state_d     = S_HDR1;
            if (pix_valid) begin
               hdr_bad_d    = 1'b1;
               frame_drop_d = ~hdr_bad_q;
            end else begin
               hdr_bad_d = hdr_bad_q;
            end
         end
         S_HDR1: begin
            pix_cnt_d = '0;
            if (pix_valid || hdr_bad_q) begin
               frame_drop_d = pix_valid & ~hdr_bad_q;
               state_d      = S_DROP;
            end else begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (sof) begin
               // Short frame: abandon it and restart on the new sync
               frame_drop_d = 1'b1;
               if (gate_ok) begin
                  fifo_wr_d   = 1'b1;
                  fifo_data_d = HDR_WORD0;
                  hdr_bad_d   = 1'b0;
                  state_d     = S_HDR0;
               end else begin
                  state_d = S_DROP;
               end
            end else if (pix_valid) begin
               if (room_ok) begin
                  fifo_wr_d   = 1'b1;
                  fifo_data_d = {8'h00, pix_data};
                  if (pix_cnt_q == PIX_LAST) begin
                     frame_done_d = 1'b1;
                     state_d      = S_IDLE;
                  end else begin
                     pix_cnt_d = pix_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                  end
               end else begin
                  frame_drop_d = 1'b1;
                  state_d      = S_DROP;
               end
            end else begin
               state_d = S_DATA;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Saturating frame-drop counter update
   always_comb begin
      if (frame_drop_d && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pix_cnt_q    <= '0;
         vs_q         <= 1'b0;
         hdr_bad_q    <= 1'b0;
         fifo_data_q  <= 32'h0000_0000;
         fifo_wr_q    <= 1'b0;
         frame_done_q <= 1'b0;
         frame_drop_q <= 1'b0;
         drop_cnt_q   <= 16'h0000;
      end else begin
         state_q      <= state_d;
         pix_cnt_q    <= pix_cnt_d;
         vs_q         <= pix_vsync;
         hdr_bad_q    <= hdr_bad_d;
         fifo_data_q  <= fifo_data_d;
         fifo_wr_q    <= fifo_wr_d;
         frame_done_q <= frame_done_d;
         frame_drop_q <= frame_drop_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign fifo_data  = fifo_data_q;
   assign fifo_wr    = fifo_wr_q;
   assign frame_done = frame_done_q;
   assign frame_drop = frame_drop_q;
   assign drop_cnt   = drop_cnt_q;

endmodule
